// File: rtl/warmboot_sequencer.sv
// Bootloader-to-user-image hand-off: drain flash/USB activity, optionally detach USB, then warmboot.
// Optional USB detach phase is enabled with `define WARMBOOT_DETACH_EN.
module warmboot_sequencer #(
    parameter int QUIET_CYCLES  = 64,
    parameter int DRAIN_TIMEOUT = 65535,
    parameter int DETACH_CYCLES = 480000,
    parameter int ARM_CYCLES    = 2
) (
    input  logic       clk_usb,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] image_sel,
    input  logic       spi_cs,
    input  logic       usb_tx_en,
    output logic       usb_pu,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy
);

    localparam int PH_MAX = (DETACH_CYCLES > ARM_CYCLES) ? DETACH_CYCLES : ARM_CYCLES;
    localparam int Q_W    = (QUIET_CYCLES  > 1) ? $clog2(QUIET_CYCLES)  : 1;
    localparam int T_W    = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int PH_W   = (PH_MAX        > 1) ? $clog2(PH_MAX)        : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        DETACH = 3'd2,
        ARM    = 3'd3,
        FIRE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            boot_req_d;
    logic [1:0]      img_q;
    logic [Q_W-1:0]  quiet_cnt;
    logic [T_W-1:0]  tmo_cnt;
    logic [PH_W-1:0] ph_cnt;

    logic quiet;
    logic req_edge;
    logic drain_done;

    assign quiet      = spi_cs & ~usb_tx_en;
    assign req_edge   = boot_req & ~boot_req_d;
    assign drain_done = (quiet && (quiet_cnt == Q_W'(QUIET_CYCLES - 1)))
                      || (tmo_cnt == T_W'(DRAIN_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_edge) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_done) begin
`ifdef WARMBOOT_DETACH_EN
                    state_nxt = DETACH;
`else
                    state_nxt = ARM;
`endif
                end
            end
            DETACH: begin
                if (ph_cnt == PH_W'(DETACH_CYCLES - 1)) state_nxt = ARM;
            end
            ARM: begin
                if (ph_cnt == PH_W'(ARM_CYCLES - 1)) state_nxt = FIRE;
            end
            FIRE: begin
                state_nxt = FIRE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change in the same cycle as the state.
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            boot_req_d <= 1'b1;
            img_q      <= 2'b00;
            quiet_cnt  <= '0;
            tmo_cnt    <= '0;
            ph_cnt     <= '0;
            usb_pu     <= 1'b1;
            wb_boot    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            boot_req_d <= boot_req;
            if (state == IDLE && req_edge) img_q <= image_sel;

            if (state_nxt != state) begin
                quiet_cnt <= '0;
                tmo_cnt   <= '0;
                ph_cnt    <= '0;
            end else if (state == DRAIN) begin
                tmo_cnt   <= tmo_cnt + 1'b1;
                quiet_cnt <= quiet ? quiet_cnt + 1'b1 : '0;
            end else if (state == DETACH || state == ARM) begin
                ph_cnt <= ph_cnt + 1'b1;
            end

`ifdef WARMBOOT_DETACH_EN
            usb_pu <= !(state_nxt == DETACH || state_nxt == ARM || state_nxt == FIRE);
`else
            usb_pu <= 1'b1;
`endif
            wb_boot <= (state_nxt == FIRE);
            busy    <= (state_nxt != IDLE);
        end
    end

    assign wb_s1 = img_q[1];
    assign wb_s0 = img_q[0];

endmodule
